// File: rtl/alu_seq.sv
`default_nettype none
// =============================================================================
// Module   : alu_seq
// Brief    : Sequential ALU. Single-cycle ops plus iterative shift-add MUL and
//            restoring DIV/MOD, present only when ALU_SEQ_MULDIV_EN is defined.
// Revision : 1.0
// =============================================================================
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       opcode,
   input  logic [WIDTH-1:0] term1,
   input  logic [WIDTH-1:0] term2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             carry,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [5:0] C_OP_ADD = 6'b010001;
   localparam logic [5:0] C_OP_SUB = 6'b010010;
   localparam logic [5:0] C_OP_CMP = 6'b010110;
   localparam logic [5:0] C_OP_TST = 6'b010111;
   localparam logic [5:0] C_OP_INC = 6'b011000;
   localparam logic [5:0] C_OP_DEC = 6'b011001;
   localparam logic [5:0] C_OP_LSR = 6'b001000;
   localparam logic [5:0] C_OP_LSL = 6'b001001;
   localparam logic [5:0] C_OP_RSR = 6'b001010;
   localparam logic [5:0] C_OP_RSL = 6'b001011;
   localparam logic [5:0] C_OP_MOV = 6'b000111;
   localparam logic [5:0] C_OP_AND = 6'b001100;
   localparam logic [5:0] C_OP_OR  = 6'b001101;
   localparam logic [5:0] C_OP_XOR = 6'b001110;
   localparam logic [5:0] C_OP_NOT = 6'b001111;

`ifdef ALU_SEQ_MULDIV_EN
   localparam logic [5:0] C_OP_MUL = 6'b010011;
   localparam logic [5:0] C_OP_DIV = 6'b010100;
   localparam logic [5:0] C_OP_MOD = 6'b010101;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FINISH = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FINISH = 2'd2} state_t;
`endif

   state_t           state_q, state_d;
   logic [5:0]       opc_q, opc_d;
   logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
   logic             carry_q, carry_d, done_q, done_d, dz_q, dz_d;

`ifdef ALU_SEQ_MULDIV_EN
   // hi/lo hold {partial product, multiplier} for MUL, {remainder, dividend/quotient} for DIV/MOD
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   w_msum, w_shift, w_diff;

   always_comb begin
      w_msum  = {1'b0, hi_q} + {1'b0, op1_q & {WIDTH{lo_q[0]}}};
      w_shift = {hi_q, lo_q[WIDTH-1]};
      w_diff  = w_shift - {1'b0, op2_q};
   end
`endif

   logic [WIDTH:0]   w_add, w_sub, w_shr, w_shl;
   logic [WIDTH-1:0] w_rot_r, w_rot_l, w_res;
   logic [CW-1:0]    w_n;
   logic             w_nz, w_v, w_c, w_dz, w_valid, w_negok;

   always_comb begin
      w_n     = CW'(op2_q % WIDTH);
      w_nz    = (w_n != '0);
      w_add   = {1'b0, op1_q} + {1'b0, op2_q};
      w_sub   = {1'b0, op1_q} - {1'b0, op2_q};
      w_shr   = {op1_q, 1'b0} >> w_n;
      w_shl   = {1'b0, op1_q} << w_n;
      w_rot_r = WIDTH'({op1_q, op1_q} >> w_n);
      w_rot_l = WIDTH'(({op1_q, op1_q} << w_n) >> WIDTH);
      w_res   = '0;
      w_v     = 1'b0;
      w_c     = 1'b0;
      w_dz    = 1'b0;
      w_valid = 1'b1;
      w_negok = 1'b1;
      case (opc_q)
         C_OP_ADD: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = (op1_q[WIDTH-1] == op2_q[WIDTH-1]) && (w_add[WIDTH-1] != op1_q[WIDTH-1]);
         end
         C_OP_SUB, C_OP_CMP: begin
            w_res = w_sub[WIDTH-1:0];
            w_c   = w_sub[WIDTH];
            w_v   = (op1_q[WIDTH-1] != op2_q[WIDTH-1]) && (w_sub[WIDTH-1] != op1_q[WIDTH-1]);
         end
         C_OP_INC: begin
            w_res = op1_q + 1'b1;
            w_v   = (op1_q == {1'b0, {(WIDTH-1){1'b1}}});
         end
         C_OP_DEC: begin
            w_res = op1_q - 1'b1;
            w_v   = (op1_q == {1'b1, {(WIDTH-1){1'b0}}});
         end
         C_OP_LSR: begin
            w_res = w_shr[WIDTH:1];
            w_c   = w_shr[0];
         end
         C_OP_LSL: begin
            w_res = w_shl[WIDTH-1:0];
            w_c   = w_shl[WIDTH];
         end
         C_OP_RSR: begin
            w_res = w_rot_r;
            w_c   = w_nz & w_rot_r[WIDTH-1];
         end
         C_OP_RSL: begin
            w_res = w_rot_l;
            w_c   = w_nz & w_rot_l[0];
         end
         C_OP_MOV: w_res = op2_q;
         C_OP_AND: w_res = op1_q & op2_q;
         C_OP_OR:  w_res = op1_q | op2_q;
         C_OP_XOR: w_res = op1_q ^ op2_q;
         C_OP_NOT: w_res = ~op1_q;
         C_OP_TST: begin
            w_res   = op1_q & op2_q;
            w_negok = 1'b0;
         end
`ifdef ALU_SEQ_MULDIV_EN
         C_OP_MUL: begin
            w_res = lo_q;
            w_v   = |hi_q;
         end
         C_OP_DIV: begin
            w_dz  = (op2_q == '0);
            w_res = w_dz ? '1 : lo_q;
         end
         C_OP_MOD: begin
            w_dz  = (op2_q == '0);
            w_res = w_dz ? op1_q : hi_q;
         end
`endif
         default: w_valid = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      opc_d    = opc_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      result_d = result_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      carry_d  = carry_q;
      dz_d     = dz_q;
      done_d   = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               opc_d   = opcode;
               op1_d   = term1;
               op2_d   = term2;
               state_d = S_FINISH;
`ifdef ALU_SEQ_MULDIV_EN
               cnt_d   = '0;
               hi_d    = '0;
               lo_d    = (opcode == C_OP_MUL) ? term2 : term1;
               // divide by zero skips the iteration and resolves in FINISH
               if ((opcode == C_OP_MUL) ||
                   (((opcode == C_OP_DIV) || (opcode == C_OP_MOD)) && (term2 != '0)))
                  state_d = S_ITER;
`endif
            end
         end
`ifdef ALU_SEQ_MULDIV_EN
         S_ITER: begin
            cnt_d = cnt_q + 1'b1;
            if (opc_q == C_OP_MUL) begin
               hi_d = w_msum[WIDTH:1];
               lo_d = {w_msum[0], lo_q[WIDTH-1:1]};
            end else if (!w_diff[WIDTH]) begin
               hi_d = w_diff[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = w_shift[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == CW'(WIDTH-1))
               state_d = S_FINISH;
         end
`endif
         S_FINISH: begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            result_d = w_res;
            zero_d   = w_valid & (w_res == '0);
            neg_d    = w_valid & w_negok & w_res[WIDTH-1];
            ovf_d    = w_v;
            carry_d  = w_c;
            dz_d     = w_dz;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         opc_q    <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         carry_q  <= 1'b0;
         dz_q     <= 1'b0;
         done_q   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         opc_q    <= opc_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
         carry_q  <= carry_d;
         dz_q     <= dz_d;
         done_q   <= done_d;
`ifdef ALU_SEQ_MULDIV_EN
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign result   = result_q;
   assign zero     = zero_q;
   assign negative = neg_q;
   assign overflow = ovf_q;
   assign carry    = carry_q;
   assign div_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_alu_seq
// Brief    : Directed and random checks of alu_seq (WIDTH = 16) against an
//            arithmetic reference model; follows ALU_SEQ_MULDIV_EN like the DUT.
// Revision : 1.0
// =============================================================================
module tb_alu_seq;

   localparam int W = 16;

   localparam logic [5:0] OP_ADD = 6'b010001, OP_SUB = 6'b010010, OP_CMP = 6'b010110;
   localparam logic [5:0] OP_TST = 6'b010111, OP_INC = 6'b011000, OP_DEC = 6'b011001;
   localparam logic [5:0] OP_LSR = 6'b001000, OP_LSL = 6'b001001, OP_RSR = 6'b001010;
   localparam logic [5:0] OP_RSL = 6'b001011, OP_MOV = 6'b000111, OP_MUL = 6'b010011;
   localparam logic [5:0] OP_DIV = 6'b010100, OP_MOD = 6'b010101, OP_AND = 6'b001100;
   localparam logic [5:0] OP_OR  = 6'b001101, OP_XOR = 6'b001110, OP_NOT = 6'b001111;

   typedef struct packed {
      logic [15:0] res;
      logic        z;
      logic        n;
      logic        v;
      logic        c;
      logic        dz;
      logic [7:0]  lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [5:0]   opcode = '0;
   logic [W-1:0] term1 = '0;
   logic [W-1:0] term2 = '0;
   logic         busy, done, zero, negative, overflow, carry, div_zero;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .opcode   (opcode),
      .term1    (term1),
      .term2    (term2),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .zero     (zero),
      .negative (negative),
      .overflow (overflow),
      .carry    (carry),
      .div_zero (div_zero)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the opcode's meaning
   function automatic exp_t model(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
      exp_t            e;
      longint unsigned ua, ub, p;
      int              sa, sb, s, n;
      bit              known;
      ua = a;
      ub = b;
      sa = int'($signed(a));
      sb = int'($signed(b));
      n  = int'(b % 16);
      e  = '0;
      e.lat = 8'd1;
      known = 1'b1;
      p  = 0;
      case (op)
         OP_ADD: begin
            p = ua + ub; s = sa + sb;
            e.c = (p > 65535); e.v = (s > 32767) || (s < -32768);
         end
         OP_SUB, OP_CMP: begin
            p = ua + 65536 - ub; s = sa - sb;
            e.c = (ua < ub); e.v = (s > 32767) || (s < -32768);
         end
         OP_INC: begin p = ua + 1; e.v = (sa + 1 > 32767); end
         OP_DEC: begin p = ua + 65535; e.v = (sa - 1 < -32768); end
         OP_LSR: begin p = ua >> n; e.c = (n != 0) && (((ua >> (n - 1)) & 1) != 0); end
         OP_LSL: begin p = ua << n; e.c = (n != 0) && (((ua >> (16 - n)) & 1) != 0); end
         OP_RSR: begin
            p = ua;
            for (int i = 0; i < n; i++) p = (p >> 1) | ((p & 1) << 15);
            e.c = (n != 0) && (p >= 32768);
         end
         OP_RSL: begin
            p = ua;
            for (int i = 0; i < n; i++) p = ((p << 1) & 65535) | (p >> 15);
            e.c = (n != 0) && ((p & 1) != 0);
         end
         OP_MOV: p = ub;
         OP_AND: p = ua & ub;
         OP_OR:  p = ua | ub;
         OP_XOR: p = ua ^ ub;
         OP_NOT: p = ua ^ 65535;
         OP_TST: p = ua & ub;
`ifdef ALU_SEQ_MULDIV_EN
         OP_MUL: begin p = ua * ub; e.v = (p > 65535); e.lat = 8'd17; end
         OP_DIV: begin
            if (ub == 0) begin p = 65535; e.dz = 1'b1; end
            else begin p = ua / ub; e.lat = 8'd17; end
         end
         OP_MOD: begin
            if (ub == 0) begin p = ua; e.dz = 1'b1; end
            else begin p = ua % ub; e.lat = 8'd17; end
         end
`endif
         default: known = 1'b0;
      endcase
      e.res = 16'(p);
      e.z   = known && (e.res == 16'h0000);
      e.n   = known && (op != OP_TST) && e.res[15];
      return e;
   endfunction

   task automatic do_op(input string tag, input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
      exp_t  e;
      int    lat;
      bit    busy_ok;
      e = model(op, a, b);
      @(negedge clk);
      start = 1'b1; opcode = op; term1 = a; term2 = b;
      @(posedge clk); #1;
      start = 1'b0; term1 = ~a; term2 = ~b;
      chk({tag, " busy_after_start"}, busy, 1'b1);
      lat = 0;
      busy_ok = 1'b1;
      do begin
         @(posedge clk); #1;
         lat++;
         if (!done && !busy) busy_ok = 1'b0;
      end while (!done && lat < 100);
      chk({tag, " latency"}, lat, e.lat);
      chk({tag, " busy_while_running"}, busy_ok, 1'b1);
      chk({tag, " busy_in_done"}, busy, 1'b0);
      chk({tag, " result"}, result, e.res);
      chk({tag, " flags_zncv"}, {zero, negative, overflow, carry}, {e.z, e.n, e.v, e.c});
      chk({tag, " div_zero"}, div_zero, e.dz);
      @(posedge clk); #1;
      chk({tag, " done_one_cycle"}, done, 1'b0);
      chk({tag, " result_held"}, result, e.res);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t       e1, e2;
      int         lat;
      bit         seen;
      logic [5:0] op;
      logic [15:0] a, b;
      logic [5:0] pool [21] = '{OP_ADD, OP_SUB, OP_CMP, OP_TST, OP_INC, OP_DEC, OP_LSR,
                                OP_LSL, OP_RSR, OP_RSL, OP_MOV, OP_MUL, OP_DIV, OP_MOD,
                                OP_AND, OP_OR, OP_XOR, OP_NOT, 6'b000000, 6'b111111, 6'b010000};

      // start held high during reset must be ignored
      start = 1'b1; opcode = OP_ADD; term1 = 16'd1; term2 = 16'd1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset result", result, 16'h0000);
      chk("reset flags", {zero, negative, overflow, carry, div_zero}, 5'b00000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("first start after reset accepted", busy, 1'b1);
      @(posedge clk); #1;
      chk("first op done", done, 1'b1);
      chk("first op result", result, 16'h0002);

      do_op("add_wrap",   OP_ADD, 16'hFFFF, 16'h0001);
      do_op("mul_ovf",    OP_MUL, 16'h0100, 16'h0100);
      do_op("div_100_7",  OP_DIV, 16'd100,  16'd7);
      do_op("mod_100_7",  OP_MOD, 16'd100,  16'd7);
      do_op("div_by_0",   OP_DIV, 16'd5,    16'd0);
      do_op("mod_by_0",   OP_MOD, 16'h1234, 16'd0);
      do_op("lsl_17",     OP_LSL, 16'h8001, 16'd17);
      do_op("rsr_1",      OP_RSR, 16'h0001, 16'd1);
      do_op("lsr_n0",     OP_LSR, 16'h8001, 16'd16);
      do_op("rsl_1",      OP_RSL, 16'h8000, 16'd1);
      do_op("sub_borrow", OP_SUB, 16'd3,    16'd5);
      do_op("cmp_ovf",    OP_CMP, 16'h8000, 16'h0001);
      do_op("inc_ovf",    OP_INC, 16'h7FFF, 16'h0000);
      do_op("dec_ovf",    OP_DEC, 16'h8000, 16'h0000);
      do_op("tst_zero",   OP_TST, 16'h00F0, 16'h0F00);
      do_op("not",        OP_NOT, 16'h00FF, 16'h0000);
      do_op("undefined",  6'b111111, 16'h1234, 16'h5678);

      // reset in the middle of a multiply
      @(negedge clk);
      start = 1'b1; opcode = OP_MUL; term1 = 16'h0100; term2 = 16'h0100;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst busy", busy, 1'b0);
      chk("mid_rst done", done, 1'b0);
      chk("mid_rst result", result, 16'h0000);
      chk("mid_rst flags", {zero, negative, overflow, carry, div_zero}, 5'b00000);
      seen = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (done) seen = 1'b1; end
      @(negedge clk);
      rst = 1'b0;
      repeat (25) begin @(posedge clk); #1; if (done) seen = 1'b1; end
      chk("mid_rst no_done_pulse", seen, 1'b0);
      do_op("add_after_rst", OP_ADD, 16'd2, 16'd3);

      // start held high across the done cycle; changes while busy are ignored
      e1 = model(OP_MUL, 16'h0123, 16'h0045);
      e2 = model(OP_ADD, 16'h1111, 16'h2222);
      @(negedge clk);
      start = 1'b1; opcode = OP_MUL; term1 = 16'h0123; term2 = 16'h0045;
      @(posedge clk); #1;
      opcode = OP_DIV; term1 = 16'hDEAD; term2 = 16'h0000;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!done && lat < 100);
      chk("b2b first latency", lat, e1.lat);
      chk("b2b first result", result, e1.res);
      chk("b2b first div_zero", div_zero, e1.dz);
      opcode = OP_ADD; term1 = 16'h1111; term2 = 16'h2222;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b second accepted", busy, 1'b1);
      @(posedge clk); #1;
      chk("b2b second done", done, 1'b1);
      chk("b2b second result", result, e2.res);

      // random operations
      for (int k = 0; k < 40; k++) begin
         op = pool[$urandom_range(0, 20)];
         a  = 16'($urandom);
         b  = 16'($urandom);
         if (op == OP_MUL && b == 16'h0000) b = 16'h0001;
         if ((op == OP_DIV || op == OP_MOD) && $urandom_range(0, 5) == 0) b = 16'h0000;
         if ((op == OP_DIV || op == OP_MOD) && $urandom_range(0, 2) == 0) b = b >> 10;
         do_op($sformatf("rand%0d_op%02h", k, op), op, a, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
